// File: rtl/seq_ctrl_unit.sv
// Instruction sequencer for a simple accumulator CPU: walks fetch/decode/execute
// phases, drives datapath strobes, and counts retired instructions.
module seq_ctrl_unit #(
  parameter int OPC_W    = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] ins,
  input  logic             mem_rdy,
  input  logic             resume,
  output logic             PC_en,
  output logic             write_r,
  output logic             read_r,
  output logic             ac_ena,
  output logic             ram_ena,
  output logic             rom_ena,
  output logic             ram_write,
  output logic             ram_read,
  output logic             rom_read,
  output logic             ad_sel,
  output logic [1:0]       fetch,
  output logic             halted,
  output logic             bus_err,
  output logic             ill_op,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDO = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STO = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_LDM = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_DEC, S_FETCH2, S_OPND, S_LOAD, S_ST_SETUP,
    S_STORE, S_ALU_RD, S_ALU_EX, S_LDM_EX, S_HALT, S_ERR
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       write_r;
    logic       read_r;
    logic       ac_ena;
    logic       ram_ena;
    logic       rom_ena;
    logic       ram_write;
    logic       ram_read;
    logic       rom_read;
    logic       ad_sel;
    logic [1:0] fetch;
    logic       halted;
    logic       ill_op;
  } out_t;

  function automatic logic is_illegal(input logic [OPC_W-1:0] op);
    return (op >> 3) != '0;
  endfunction

  function automatic out_t decode(input state_t s, input logic [OPC_W-1:0] op);
    out_t o;
    o = '0;
    case (s)
      S_FETCH1, S_FETCH2: begin
        o.rom_ena  = 1'b1;
        o.rom_read = 1'b1;
        o.fetch    = 2'b01;
      end
      S_DEC: begin
        o.pc_en  = 1'b1;
        o.ill_op = is_illegal(op);
      end
      S_OPND: o.pc_en = 1'b1;
      S_LOAD: begin
        o.write_r = 1'b1;
        o.ad_sel  = 1'b1;
        if (op[2:0] == OP_LDO) begin
          o.rom_ena  = 1'b1;
          o.rom_read = 1'b1;
        end else if (op[2:0] == OP_LDA) begin
          o.ram_ena  = 1'b1;
          o.ram_read = 1'b1;
        end
      end
      S_ST_SETUP, S_ALU_RD: begin
        o.read_r = 1'b1;
        o.fetch  = 2'b01;
      end
      S_STORE: begin
        o.ram_ena   = 1'b1;
        o.ram_write = 1'b1;
        o.ad_sel    = 1'b1;
        o.fetch     = 2'b10;
      end
      S_ALU_EX: begin
        o.ac_ena = 1'b1;
        o.fetch  = 2'b01;
      end
      S_LDM_EX: begin
        o.write_r = 1'b1;
        o.ac_ena  = 1'b1;
      end
      S_HALT:  o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t             r_state;
  logic [OPC_W-1:0]   r_op_q;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bus_err;
  out_t               r_out;

  state_t             w_nxt_state;
  logic [OPC_W-1:0]   w_nxt_op;
  logic               w_in_wait;
  logic               w_timeout;
  logic               w_retire;

  assign w_in_wait = (r_state == S_FETCH1) || (r_state == S_FETCH2) ||
                     (r_state == S_LOAD)   || (r_state == S_STORE);
  // mem_rdy on the last allowed cycle takes priority because it is tested first below
  assign w_timeout = w_in_wait && !mem_rdy && (r_wait == WAIT_LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op_q;
    case (r_state)
      S_IDLE:   w_nxt_state = S_FETCH1;
      S_FETCH1: begin
        if (mem_rdy) begin
          w_nxt_state = S_DEC;
          w_nxt_op    = ins;
        end else if (w_timeout) begin
          w_nxt_state = S_ERR;
        end
      end
      S_DEC: begin
        if (is_illegal(r_op_q)) begin
          w_nxt_state = S_FETCH1;
        end else begin
          case (r_op_q[2:0])
            OP_NOP:         w_nxt_state = S_FETCH1;
            OP_HLT:         w_nxt_state = S_HALT;
            OP_PRE, OP_ADD: w_nxt_state = S_ALU_RD;
            OP_LDM:         w_nxt_state = S_LDM_EX;
            default:        w_nxt_state = S_FETCH2;
          endcase
        end
      end
      S_FETCH2: begin
        if (mem_rdy)        w_nxt_state = S_OPND;
        else if (w_timeout) w_nxt_state = S_ERR;
      end
      S_OPND:     w_nxt_state = (r_op_q[2:0] == OP_STO) ? S_ST_SETUP : S_LOAD;
      S_LOAD, S_STORE: begin
        if (mem_rdy)        w_nxt_state = S_FETCH1;
        else if (w_timeout) w_nxt_state = S_ERR;
      end
      S_ST_SETUP: w_nxt_state = S_STORE;
      S_ALU_RD:   w_nxt_state = S_ALU_EX;
      S_ALU_EX:   w_nxt_state = S_FETCH1;
      S_LDM_EX:   w_nxt_state = S_FETCH1;
      S_HALT:     if (resume) w_nxt_state = S_FETCH1;
      default:    w_nxt_state = S_ERR;
    endcase
  end

  // HALT->FETCH1 and IDLE->FETCH1 are deliberately not retirements
  assign w_retire = ((w_nxt_state == S_FETCH1) &&
                     ((r_state == S_DEC)    || (r_state == S_LOAD) ||
                      (r_state == S_STORE)  || (r_state == S_ALU_EX) ||
                      (r_state == S_LDM_EX))) ||
                    ((w_nxt_state == S_HALT) && (r_state != S_HALT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op_q    <= '0;
      r_wait    <= '0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_op_q  <= w_nxt_op;
      if ((w_nxt_state == r_state) && w_in_wait && !mem_rdy) r_wait <= r_wait + 1'b1;
      else                                                   r_wait <= '0;
      if (w_retire && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      r_bus_err <= r_bus_err | (w_nxt_state == S_ERR);
      // outputs are decoded from the upcoming state so they line up with it
      r_out <= decode(w_nxt_state, w_nxt_op);
    end
  end

  assign PC_en     = r_out.pc_en;
  assign write_r   = r_out.write_r;
  assign read_r    = r_out.read_r;
  assign ac_ena    = r_out.ac_ena;
  assign ram_ena   = r_out.ram_ena;
  assign rom_ena   = r_out.rom_ena;
  assign ram_write = r_out.ram_write;
  assign ram_read  = r_out.ram_read;
  assign rom_read  = r_out.rom_read;
  assign ad_sel    = r_out.ad_sel;
  assign fetch     = r_out.fetch;
  assign halted    = r_out.halted;
  assign ill_op    = r_out.ill_op;
  assign bus_err   = r_bus_err;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed and randomized bench for seq_ctrl_unit against a phase-name reference model.
module tb_seq_ctrl_unit;

  localparam int OPC_W    = 4;
  localparam int CNT_W    = 3;
  localparam int MAX_WAIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [OPC_W-1:0] ins = '0;
  logic             mem_rdy = 1'b0;
  logic             resume = 1'b0;
  logic             PC_en, write_r, read_r, ac_ena, ram_ena, rom_ena;
  logic             ram_write, ram_read, rom_read, ad_sel, halted, bus_err, ill_op;
  logic [1:0]       fetch;
  logic [CNT_W-1:0] instr_cnt;

  seq_ctrl_unit #(.OPC_W(OPC_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .ins(ins), .mem_rdy(mem_rdy), .resume(resume),
    .PC_en(PC_en), .write_r(write_r), .read_r(read_r), .ac_ena(ac_ena),
    .ram_ena(ram_ena), .rom_ena(rom_ena), .ram_write(ram_write),
    .ram_read(ram_read), .rom_read(rom_read), .ad_sel(ad_sel),
    .fetch(fetch), .halted(halted), .bus_err(bus_err), .ill_op(ill_op),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  string m_st = "IDLE";
  int    m_op = 0;
  int    m_wait = 0;
  int    m_cnt = 0;
  bit    m_berr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h model_phase=%s t=%0t", tag, got, exp, m_st, $time);
    end
  endtask

  function automatic bit illegal_op(input int op);
    return (op >> 3) != 0;
  endfunction

  function automatic bit is_wait_phase(input string s);
    return (s == "FETCH1") || (s == "FETCH2") || (s == "LOAD") || (s == "STORE");
  endfunction

  // {PC_en,write_r,read_r,ac_ena,ram_ena,rom_ena,ram_write,ram_read,rom_read,ad_sel,fetch,halted,ill_op}
  function automatic logic [13:0] exp_out(input string s, input int op);
    bit pc, wr, rd, ac, rame, rome, ramw, ramr, romr, ad, hl, il;
    bit [1:0] fe;
    {pc, wr, rd, ac, rame, rome, ramw, ramr, romr, ad, hl, il} = '0;
    fe = 2'b00;
    if (s == "FETCH1" || s == "FETCH2") begin rome = 1; romr = 1; fe = 2'b01; end
    if (s == "DEC") begin pc = 1; il = illegal_op(op); end
    if (s == "OPND") pc = 1;
    if (s == "LOAD") begin
      wr = 1; ad = 1;
      if (op % 8 == 1) begin rome = 1; romr = 1; end
      else             begin rame = 1; ramr = 1; end
    end
    if (s == "ST_SETUP" || s == "ALU_RD") begin rd = 1; fe = 2'b01; end
    if (s == "STORE") begin rame = 1; ramw = 1; ad = 1; fe = 2'b10; end
    if (s == "ALU_EX") begin ac = 1; fe = 2'b01; end
    if (s == "LDM_EX") begin wr = 1; ac = 1; end
    if (s == "HALT") hl = 1;
    return {pc, wr, rd, ac, rame, rome, ramw, ramr, romr, ad, fe, hl, il};
  endfunction

  function automatic logic [13:0] dut_out();
    return {PC_en, write_r, read_r, ac_ena, ram_ena, rom_ena, ram_write,
            ram_read, rom_read, ad_sel, fetch, halted, ill_op};
  endfunction

  // One clock: the model computes its successor from the inputs held across the edge.
  task automatic step();
    string nxt;
    int    nop, nwait, ncnt, low;
    bit    nberr, tmo;
    nxt = m_st; nop = m_op; nwait = 0; ncnt = m_cnt; nberr = m_berr;
    if (!rst) begin
      nxt = "IDLE"; nop = 0; ncnt = 0; nberr = 0;
    end else begin
      tmo = !mem_rdy && (m_wait == MAX_WAIT - 1);
      low = m_op % 8;
      case (m_st)
        "IDLE":     nxt = "FETCH1";
        "FETCH1":   if (mem_rdy) begin nxt = "DEC"; nop = int'(ins); end else if (tmo) nxt = "ERR";
        "DEC": begin
          if (illegal_op(m_op) || low == 0) nxt = "FETCH1";
          else if (low == 7)                nxt = "HALT";
          else if (low == 4 || low == 5)    nxt = "ALU_RD";
          else if (low == 6)                nxt = "LDM_EX";
          else                              nxt = "FETCH2";
        end
        "FETCH2":   if (mem_rdy) nxt = "OPND"; else if (tmo) nxt = "ERR";
        "OPND":     nxt = (low == 3) ? "ST_SETUP" : "LOAD";
        "LOAD", "STORE": if (mem_rdy) nxt = "FETCH1"; else if (tmo) nxt = "ERR";
        "ST_SETUP": nxt = "STORE";
        "ALU_RD":   nxt = "ALU_EX";
        "ALU_EX", "LDM_EX": nxt = "FETCH1";
        "HALT":     if (resume) nxt = "FETCH1";
        default:    nxt = "ERR";
      endcase
      if (nxt == m_st && is_wait_phase(m_st) && !mem_rdy) nwait = m_wait + 1;
      if ((nxt == "FETCH1" && (m_st == "DEC" || m_st == "LOAD" || m_st == "STORE" ||
                               m_st == "ALU_EX" || m_st == "LDM_EX")) ||
          (nxt == "HALT" && m_st != "HALT"))
        ncnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (nxt == "ERR") nberr = 1;
    end
    @(posedge clk);
    #1;
    m_st = nxt; m_op = nop; m_wait = nwait; m_cnt = ncnt; m_berr = nberr;
    chk("outputs", 32'(dut_out()), 32'(exp_out(m_st, m_op)));
    chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
    chk("bus_err", 32'(bus_err), 32'(m_berr));
  endtask

  task automatic do_reset();
    rst = 1'b0; resume = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  initial begin
    // reset and NOP loop
    mem_rdy = 1'b1; ins = 4'd0;
    do_reset();
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    chk("reset_outs", 32'(dut_out()), 32'd0);
    repeat (7) step();
    chk("nop_cnt3", 32'(instr_cnt), 32'd3);

    // STO flow
    do_reset(); ins = 4'd3;
    repeat (6) step();
    chk("sto_ram_write", 32'(ram_write), 32'd1);
    chk("sto_fetch", 32'(fetch), 32'd2);
    step();
    chk("sto_cnt", 32'(instr_cnt), 32'd1);
    chk("sto_back_f1", 32'(rom_read), 32'd1);

    // LDA with three wait cycles, ins changed to ADD mid-LOAD
    do_reset(); ins = 4'd2;
    repeat (5) step();
    mem_rdy = 1'b0; ins = 4'd5;
    for (int i = 0; i < 3; i++) begin
      chk("lda_ram_read", 32'(ram_read), 32'd1);
      step();
    end
    chk("lda_ram_read_last", 32'(ram_read), 32'd1);
    mem_rdy = 1'b1;
    step();
    chk("lda_done_rom", 32'(rom_read), 32'd1);
    chk("lda_done_cnt", 32'(instr_cnt), 32'd1);

    // timeout in FETCH1, then rdy on the last allowed cycle
    do_reset(); mem_rdy = 1'b0;
    repeat (5) step();
    chk("timeout_berr", 32'(bus_err), 32'd1);
    chk("timeout_outs", 32'(dut_out()), 32'd0);
    do_reset(); mem_rdy = 1'b0;
    repeat (4) step();
    mem_rdy = 1'b1;
    step();
    chk("lastcyc_dec", 32'(PC_en), 32'd1);
    chk("lastcyc_berr", 32'(bus_err), 32'd0);

    // HALT and resume
    do_reset(); ins = 4'd7;
    repeat (6) step();
    chk("halt_held", 32'(halted), 32'd1);
    chk("halt_cnt", 32'(instr_cnt), 32'd1);
    resume = 1'b1; step(); resume = 1'b0;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_f1", 32'(rom_read), 32'd1);

    // illegal high opcode bit
    do_reset(); ins = 4'b1000;
    repeat (2) step();
    chk("ill_pulse", 32'(ill_op), 32'd1);
    step();
    chk("ill_clear", 32'(ill_op), 32'd0);
    chk("ill_f1", 32'(rom_read), 32'd1);

    // counter saturation
    do_reset(); ins = 4'd0;
    repeat (19) step();
    chk("cnt_sat", 32'(instr_cnt), 32'(CNT_MAX));

    // reset in the middle of STORE
    do_reset(); ins = 4'd3;
    repeat (6) step();
    mem_rdy = 1'b0; step();
    rst = 1'b0; step();
    chk("rst_store_outs", 32'(dut_out()), 32'd0);
    rst = 1'b1; mem_rdy = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) != 0) && !(m_st == "ERR" && $urandom_range(0, 7) == 0);
      mem_rdy = ($urandom_range(0, 9) < 6);
      resume  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) ins = OPC_W'($urandom_range(0, 15));
      else                           ins = OPC_W'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_ctrl_unit.md
SEQ_CTRL_UNIT -- requirements
Module: seq_ctrl_unit

Interface
REQ-001 Parameter OPC_W, default 3: instruction opcode width; SHALL be >= 3.
REQ-002 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-003 Parameter MAX_WAIT, default 15: maximum cycles a memory state waits for mem_rdy before bus error; SHALL be >= 1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 ins  in  OPC_W  opcode from instruction register.
REQ-007 mem_rdy  in  1  ROM/RAM access complete.
REQ-008 resume  in  1  leave HALT.
REQ-009 PC_en, write_r, read_r, ac_ena, ram_ena, rom_ena, ram_write, ram_read, rom_read, ad_sel  out  1 each  datapath strobes.
REQ-010 fetch  out  2  fetch phase: 00 none, 01 opcode/operand, 10 store.
REQ-011 halted  out  1  high while in HALT.
REQ-012 bus_err  out  1  sticky memory-timeout flag.
REQ-013 ill_op  out  1  one-cycle pulse on illegal opcode.
REQ-014 instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-015 Opcodes (low 3 bits): NOP=0, LDO=1, LDA=2, STO=3, PRE=4, ADD=5, LDM=6, HLT=7; any nonzero bit above bit 2 SHALL make the opcode illegal.
REQ-016 States: IDLE, FETCH1, DEC, FETCH2, OPND, LOAD, ST_SETUP, STORE, ALU_RD, ALU_EX, LDM_EX, HALT, ERR.
REQ-017 IDLE->FETCH1 unconditionally; FETCH1->DEC when mem_rdy=1, else hold.
REQ-018 DEC SHALL latch ins into op_q; later states decode op_q only, never live ins.
REQ-019 DEC next: NOP->FETCH1; illegal->FETCH1 with ill_op=1 for that cycle; HLT->HALT; PRE/ADD->ALU_RD; LDM->LDM_EX; LDO/LDA/STO->FETCH2.
REQ-020 FETCH2->OPND on mem_rdy; OPND: LDO/LDA->LOAD, STO->ST_SETUP.
REQ-021 LOAD->FETCH1 on mem_rdy; ST_SETUP->STORE; STORE->FETCH1 on mem_rdy; ALU_RD->ALU_EX->FETCH1; LDM_EX->FETCH1 after one cycle.
REQ-022 HALT->FETCH1 when resume=1, else hold; resume ignored in all other states.
REQ-023 Wait states FETCH1, FETCH2, LOAD, STORE: a wait counter clears on entry and increments each cycle mem_rdy=0; if mem_rdy=0 when counter equals MAX_WAIT-1, next state ERR and bus_err=1.
REQ-024 ERR SHALL hold until reset, all strobes 0, fetch=00; bus_err stays 1 until reset.
REQ-025 mem_rdy=1 on the last allowed cycle SHALL win over timeout.
REQ-026 Outputs are decoded from state and op_q only (Moore); held constant through wait cycles; unlisted strobes 0.
REQ-027 FETCH1, FETCH2: rom_ena=rom_read=1, fetch=01.
REQ-028 DEC, OPND: PC_en=1.
REQ-029 LOAD: write_r=1, ad_sel=1; op_q=LDO -> rom_ena=rom_read=1; LDA -> ram_ena=ram_read=1.
REQ-030 ST_SETUP, ALU_RD: read_r=1, fetch=01. STORE: ram_ena=ram_write=1, ad_sel=1, fetch=10.
REQ-031 ALU_EX: ac_ena=1, fetch=01. LDM_EX: write_r=1, ac_ena=1. HALT: halted=1.
REQ-032 instr_cnt increments by 1 on each transition into FETCH1 from DEC, LOAD, STORE, ALU_EX, LDM_EX, and on entry to HALT; saturates at all-ones, no wrap.

Reset
REQ-033 rst=0 at a clock edge SHALL force state IDLE, op_q=0, wait counter 0, instr_cnt=0, bus_err=0, from any state including mid-wait, HALT and ERR.
REQ-034 While in IDLE/reset all outputs SHALL be 0.

Verification
REQ-035 Reset release, ins=NOP, mem_rdy=1 always -> IDLE,FETCH1,DEC repeating; instr_cnt=3 after 3 FETCH1-DEC loops.
REQ-036 ins=STO, mem_rdy=1 -> FETCH1,DEC,FETCH2,OPND,ST_SETUP,STORE,FETCH1; STORE shows ram_write=1, fetch=10, instr_cnt +1.
REQ-037 ins=LDA, mem_rdy low 3 cycles in LOAD -> LOAD held 4 cycles, ram_read=1 throughout, ins changed to ADD mid-LOAD has no effect.
REQ-038 MAX_WAIT=4, mem_rdy=0 in FETCH1 -> ERR after 4 cycles, bus_err=1; mem_rdy=1 on 4th cycle instead -> DEC, bus_err=0.
REQ-039 ins=HLT -> halted=1 until resume=1 pulse, then FETCH1; OPC_W=4, ins=4'b1000 -> ill_op pulse, FETCH1.
REQ-040 CNT_W=2, 5 NOPs -> instr_cnt=3 (saturated); rst=0 mid-STORE -> all outputs 0, IDLE next cycle.
